// File: rtl/seq_bw_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_bw_multiplier_if
//   Operand/result handshake bundle for seq_bw_multiplier.
//   Signals:
//     in_valid  : operand pair presented (master -> slave)
//     in_ready  : multiplier can accept operands (slave -> master)
//     a, b      : multiplicand / multiplier (master -> slave)
//     sgn       : 1 = two's-complement operands, 0 = unsigned (master -> slave)
//     out_valid : product valid (slave -> master)
//     out_ready : consumer takes product (master -> slave)
//     product   : A_W+B_W bit result (slave -> master)
//     busy      : multiplier is calculating or holding a result (slave -> master)
//   Modports: master = operand source / result sink, slave = multiplier.
// -----------------------------------------------------------------------------
interface seq_bw_multiplier_if #(
  parameter int A_W = 8,
  parameter int B_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_W-1:0]       a;
  logic [B_W-1:0]       b;
  logic                 sgn;
  logic                 out_valid;
  logic                 out_ready;
  logic [A_W+B_W-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_bw_multiplier.sv
// -----------------------------------------------------------------------------
// seq_bw_multiplier
//   Iterative shift-add A_W x B_W multiplier, unsigned or two's-complement per
//   operation. One multiplier bit is consumed per cycle; with the macro
//   MULT_RADIX4_EN defined, two bits per cycle (B_W must then be even).
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : seq_bw_multiplier_if.slave (in_valid/in_ready/a/b/sgn,
//             out_valid/out_ready/product, busy)
//   Flow: IDLE accepts operands, CALC runs B_W (or B_W/2) add steps, DONE
//   holds the product until out_ready.
// -----------------------------------------------------------------------------
module seq_bw_multiplier #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  localparam int CNT_W = $clog2(B_W) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_bw_multiplier_if.slave   bus
);

  localparam int W = A_W + B_W;
`ifdef MULT_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int ITER = B_W / STEP;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  // Multiplicand extended to full width and pre-shifted to the current row.
  logic [W-1:0]    mcand_q, mcand_d;
  // Multiplier shifted right so the current row's bits sit at the bottom.
  logic [B_W-1:0]  mplier_q, mplier_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            last_row;
  logic [W-1:0]    term_lo;
  logic [W-1:0]    acc_sum;
`ifdef MULT_RADIX4_EN
  logic [W-1:0]    term_hi;
`endif

  assign last_row = (cnt_q == LAST_CNT);

  // Partial-product accumulation. In signed mode the most significant
  // multiplier bit has negative weight, so its row is subtracted.
  always_comb begin
    term_lo = mplier_q[0] ? mcand_q : '0;
`ifdef MULT_RADIX4_EN
    // Pair value {b1,b0} = 2*b1 + b0, or -2*b1 + b0 for the signed top pair.
    term_hi = mplier_q[1] ? {mcand_q[W-2:0], 1'b0} : '0;
    if (sgn_q && last_row) begin
      acc_sum = acc_q + term_lo - term_hi;
    end else begin
      acc_sum = acc_q + term_lo + term_hi;
    end
`else
    if (sgn_q && last_row) begin
      acc_sum = acc_q - term_lo;
    end else begin
      acc_sum = acc_q + term_lo;
    end
`endif
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    sgn_d        = sgn_q;
    acc_d        = acc_q;
    product_d    = product_q;
    cnt_d        = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mcand_d  = bus.sgn ? {{B_W{bus.a[A_W-1]}}, bus.a}
                             : {{B_W{1'b0}}, bus.a};
          mplier_d = bus.b;
          sgn_d    = bus.sgn;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + 1'b1;
        if (last_row) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sgn_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sgn_q     <= sgn_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_seq_bw_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_bw_multiplier
//   Self-checking bench for seq_bw_multiplier (A_W = B_W = 8): directed vector
//   table, backpressure, reset during CALC, and randomised back-to-back ops.
// -----------------------------------------------------------------------------
module tb_seq_bw_multiplier;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_bw_multiplier_if #(.A_W(8), .B_W(8)) bus ();

  seq_bw_multiplier #(.A_W(8), .B_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
    int          stall;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one operation from IDLE: present operands, count cycles to out_valid,
  // optionally stall the consumer, then hand off and confirm return to IDLE.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input logic [15:0] exp, input int stall, input string nm);
    int cyc;
    @(negedge clk);
    check({nm, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.sgn       = sv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.sgn      = 1'($urandom);
    check({nm, ".busy"}, 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, ".latency"}, 32'(cyc), 32'(LAT));
    check({nm, ".product"}, 32'(bus.product), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({nm, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, ".hold_product"}, 32'(bus.product), 32'(exp));
      check({nm, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, ".handoff_valid"}, 32'(bus.out_valid), 32'd0);
    check({nm, ".handoff_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({nm, ".retain_product"}, 32'(bus.product), 32'(exp));
    $display("op %s a=%02h b=%02h sgn=%0d stall=%0d product=%04h exp=%04h lat=%0d",
             nm, av, bv, sv, stall, bus.product, exp, cyc);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    int pa;
    int pb;
    if (sv) begin
      pa = int'($signed(av));
      pb = int'($signed(bv));
    end else begin
      pa = int'(av);
      pb = int'(bv);
    end
    return 16'(pa * pb);
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u_ff_ff"};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, 0, "s_80_80"};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, 0, "s_ff_01"};
    vecs[3] = '{8'h7F, 8'h80, 1'b1, 16'hC080, 0, "s_7f_80"};
    vecs[4] = '{8'h80, 8'h02, 1'b0, 16'h0100, 0, "u_80_02"};
    vecs[5] = '{8'h80, 8'h02, 1'b1, 16'hFF00, 0, "s_80_02"};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 5, "bp_12_34"};
    vecs[7] = '{8'h00, 8'hA5, 1'b1, 16'h0000, 0, "s_00_a5"};
    vecs[8] = '{8'h80, 8'h7F, 1'b1, 16'hC080, 2, "s_80_7f"};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].stall, vecs[i].name);
    end

    // Reset during CALC: 12 x 10 is discarded, next op 3 x 5 is clean.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'd12;
    bus.b        = 8'd10;
    bus.sgn      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.product", 32'(bus.product), 32'd0);
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      check("midrst.no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      check("postrst.no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(8'd3, 8'd5, 1'b0, 16'd15, 0, "post_rst_3x5");

    // Random back-to-back with occasional consumer stalls.
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      int         st;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      st = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), st, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
